// File: rtl/lsq_mem_unit.sv
// Memory-side endpoint of the ex_stage LSQ: dual-enqueue circular queue issuing
// in order to the memory bus, with one outstanding load and completion broadcast.
module lsq_mem_unit #(
  parameter int QUEUE_DEPTH = 8,
  parameter int PTR_BITS    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  LSQ_tag_in_1,
  input  logic [63:0] LSQ_address_in_1,
  input  logic [63:0] LSQ_value_in_1,
  input  logic        LSQ_store_in_1,
  input  logic        LSQ_valid_in_1,
  input  logic [4:0]  LSQ_tag_in_2,
  input  logic [63:0] LSQ_address_in_2,
  input  logic [63:0] LSQ_value_in_2,
  input  logic        LSQ_store_in_2,
  input  logic        LSQ_valid_in_2,
  output logic        lsq_stall_1,
  output logic        lsq_stall_2,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [4:0]  MEM_tag_out,
  output logic [63:0] MEM_value_out,
  output logic        MEM_valid_out
);

  localparam int CW = PTR_BITS + 1;
  localparam logic [CW-1:0]       DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE = {{(PTR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_DATA = 1'b1} state_t;

  state_t              state_r, state_next_s;
  logic [4:0]          q_tag_r   [QUEUE_DEPTH];
  logic [63:0]         q_addr_r  [QUEUE_DEPTH];
  logic [63:0]         q_value_r [QUEUE_DEPTH];
  logic                q_store_r [QUEUE_DEPTH];
  logic [PTR_BITS-1:0] head_r, tail_r, idx2_s, enq_ptr_s;
  logic [CW-1:0]       count_r, free_s, count_next_s;
  logic [3:0]          pend_mem_tag_r;
  logic [4:0]          pend_rob_tag_r;
  logic                enq1_s, enq2_s, has_head_s, accept_s, ret_s, head_store_s;

  assign free_s       = DEPTH_C - count_r;
  assign lsq_stall_1  = (free_s == {CW{1'b0}});
  assign lsq_stall_2  = (free_s < CW'(2));
  assign enq1_s       = LSQ_valid_in_1 && !lsq_stall_1;
  assign enq2_s       = LSQ_valid_in_2 && !lsq_stall_2;
  assign idx2_s       = enq1_s ? (tail_r + PTR_ONE) : tail_r;
  assign enq_ptr_s    = PTR_BITS'(enq1_s) + PTR_BITS'(enq2_s);
  assign has_head_s   = (count_r != {CW{1'b0}});
  assign head_store_s = q_store_r[head_r];
  assign accept_s     = (state_r == IDLE) && has_head_s && (mem2proc_response != 4'd0);
  assign ret_s        = (state_r == WAIT_DATA) && (mem2proc_tag != 4'd0) &&
                        (mem2proc_tag == pend_mem_tag_r);
  assign count_next_s = count_r + CW'(enq1_s) + CW'(enq2_s) - CW'(accept_s);

  // Drive the queue head onto the memory bus while idle
  always_comb begin
    proc2mem_command = 2'd0;
    proc2mem_addr    = 64'd0;
    proc2mem_data    = 64'd0;
    if ((state_r == IDLE) && has_head_s) begin
      proc2mem_command = head_store_s ? 2'd2 : 2'd1;
      proc2mem_addr    = {q_addr_r[head_r][63:3], 3'b000};
      proc2mem_data    = head_store_s ? q_value_r[head_r] : 64'd0;
    end else begin
      proc2mem_command = 2'd0;
      proc2mem_addr    = 64'd0;
      proc2mem_data    = 64'd0;
    end
  end

  // Next-state logic: an accepted load waits for its tagged data
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !head_store_s) state_next_s = WAIT_DATA;
        else                           state_next_s = IDLE;
      end
      WAIT_DATA: begin
        if (ret_s) state_next_s = IDLE;
        else       state_next_s = WAIT_DATA;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Queue payload storage; contents are don't-care outside head..tail
  always_ff @(posedge clock) begin
    if (enq1_s) begin
      q_tag_r[tail_r]   <= LSQ_tag_in_1;
      q_addr_r[tail_r]  <= LSQ_address_in_1;
      q_value_r[tail_r] <= LSQ_value_in_1;
      q_store_r[tail_r] <= LSQ_store_in_1;
    end
    if (enq2_s) begin
      q_tag_r[idx2_s]   <= LSQ_tag_in_2;
      q_addr_r[idx2_s]  <= LSQ_address_in_2;
      q_value_r[idx2_s] <= LSQ_value_in_2;
      q_store_r[idx2_s] <= LSQ_store_in_2;
    end
  end

  // Pointers, FSM state, pending-load tags and the completion broadcast
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r         <= {PTR_BITS{1'b0}};
      tail_r         <= {PTR_BITS{1'b0}};
      count_r        <= {CW{1'b0}};
      state_r        <= IDLE;
      pend_mem_tag_r <= 4'd0;
      pend_rob_tag_r <= 5'd0;
      MEM_tag_out    <= 5'd0;
      MEM_value_out  <= 64'd0;
      MEM_valid_out  <= 1'b0;
    end else begin
      tail_r  <= tail_r + enq_ptr_s;
      head_r  <= accept_s ? (head_r + PTR_ONE) : head_r;
      count_r <= count_next_s;
      state_r <= state_next_s;
      if (accept_s && head_store_s) begin
        MEM_valid_out <= 1'b1;
        MEM_tag_out   <= q_tag_r[head_r];
        MEM_value_out <= 64'd0;
      end else if (accept_s) begin
        MEM_valid_out  <= 1'b0;
        pend_mem_tag_r <= mem2proc_response;
        pend_rob_tag_r <= q_tag_r[head_r];
      end else if (ret_s) begin
        MEM_valid_out <= 1'b1;
        MEM_tag_out   <= pend_rob_tag_r;
        MEM_value_out <= mem2proc_data;
      end else begin
        MEM_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsq_mem_unit.sv
// Directed bench for lsq_mem_unit: expected completions are queued when
// stimulus is driven and popped whenever MEM_valid_out pulses.
module tb_lsq_mem_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  tag1, tag2;
  logic [63:0] addr1, addr2, val1, val2;
  logic        st1, st2, v1, v2;
  logic        stall1, stall2;
  logic [1:0]  cmd;
  logic [63:0] maddr, mdata;
  logic [3:0]  resp, mtag;
  logic [63:0] rdata;
  logic [4:0]  otag;
  logic [63:0] oval;
  logic        ovalid;

  typedef struct { logic [4:0] tag; logic [63:0] value; } comp_t;
  comp_t sb[$];
  int total = 0;
  int bad   = 0;

  lsq_mem_unit dut (
    .clock(clock), .reset(reset),
    .LSQ_tag_in_1(tag1), .LSQ_address_in_1(addr1), .LSQ_value_in_1(val1),
    .LSQ_store_in_1(st1), .LSQ_valid_in_1(v1),
    .LSQ_tag_in_2(tag2), .LSQ_address_in_2(addr2), .LSQ_value_in_2(val2),
    .LSQ_store_in_2(st2), .LSQ_valid_in_2(v2),
    .lsq_stall_1(stall1), .lsq_stall_2(stall2),
    .proc2mem_command(cmd), .proc2mem_addr(maddr), .proc2mem_data(mdata),
    .mem2proc_response(resp), .mem2proc_data(rdata), .mem2proc_tag(mtag),
    .MEM_tag_out(otag), .MEM_value_out(oval), .MEM_valid_out(ovalid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] t, input logic [63:0] v);
    comp_t e;
    e.tag = t;
    e.value = v;
    sb.push_back(e);
  endtask

  // Advance one clock, then compare any completion against the scoreboard
  task automatic cyc();
    comp_t e;
    @(posedge clock);
    #1;
    if (ovalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {63'd0, ovalid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("comp_tag", {59'd0, otag}, {59'd0, e.tag});
        chk("comp_value", oval, e.value);
      end
    end
  endtask

  task automatic idle_bus();
    v1 = 1'b0; v2 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    tag1 = 5'd0; tag2 = 5'd0; addr1 = 64'd0; addr2 = 64'd0; val1 = 64'd0; val2 = 64'd0;
  endtask

  initial begin
    reset = 1'b1;
    idle_bus();
    resp = 4'd0; mtag = 4'd0; rdata = 64'd0;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    chk("rst_valid", {63'd0, ovalid}, 64'd0);
    chk("rst_tag", {59'd0, otag}, 64'd0);
    chk("rst_value", oval, 64'd0);
    chk("rst_cmd", {62'd0, cmd}, 64'd0);
    chk("rst_addr", maddr, 64'd0);
    chk("rst_data", mdata, 64'd0);
    chk("rst_stalls", {62'd0, stall1, stall2}, 64'd0);

    // Single load, unaligned address
    v1 = 1'b1; tag1 = 5'd5; addr1 = 64'h1007; st1 = 1'b0; val1 = 64'h1234;
    cyc();
    idle_bus();
    resp = 4'd3;
    #1;
    chk("ld_cmd", {62'd0, cmd}, 64'd1);
    chk("ld_addr", maddr, 64'h1000);
    chk("ld_data", mdata, 64'd0);
    push(5'd5, 64'hDEAD);
    cyc();
    resp = 4'd0;
    #1;
    chk("ld_wait_cmd", {62'd0, cmd}, 64'd0);
    cyc();
    mtag = 4'd3; rdata = 64'hDEAD;
    cyc();
    chk("ld_valid", {63'd0, ovalid}, 64'd1);
    mtag = 4'd0; rdata = 64'd0;
    cyc();
    chk("ld_pulse_end", {63'd0, ovalid}, 64'd0);
    chk("ld_tag_hold", {59'd0, otag}, 64'd5);

    // Store on bus 1 and load on bus 2 in the same cycle
    v1 = 1'b1; tag1 = 5'd2; addr1 = 64'h2000; st1 = 1'b1; val1 = 64'h1111;
    v2 = 1'b1; tag2 = 5'd9; addr2 = 64'h3008; st2 = 1'b0; val2 = 64'h2222;
    cyc();
    idle_bus();
    resp = 4'd1;
    #1;
    chk("st_cmd", {62'd0, cmd}, 64'd2);
    chk("st_addr", maddr, 64'h2000);
    chk("st_data", mdata, 64'h1111);
    push(5'd2, 64'd0);
    cyc();
    chk("st_valid", {63'd0, ovalid}, 64'd1);
    chk("ld2_cmd", {62'd0, cmd}, 64'd1);
    chk("ld2_addr", maddr, 64'h3008);
    chk("ld2_data", mdata, 64'd0);
    push(5'd9, 64'hBEEF);
    cyc();
    chk("ld2_wait_cmd", {62'd0, cmd}, 64'd0);
    mtag = 4'd2; rdata = 64'h5555;
    cyc();
    chk("nonmatch_ignored", {63'd0, ovalid}, 64'd0);
    mtag = 4'd1; rdata = 64'hBEEF;
    cyc();
    mtag = 4'd0; rdata = 64'd0; resp = 4'd0;
    chk("sb_empty_1", 64'(sb.size()), 64'd0);

    // Response withheld: head request must stay stable
    v1 = 1'b1; tag1 = 5'd7; addr1 = 64'h40FF; st1 = 1'b0;
    cyc();
    idle_bus();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_cmd", {62'd0, cmd}, 64'd1);
      chk("hold_addr", maddr, 64'h40F8);
      chk("hold_data", mdata, 64'd0);
      cyc();
      chk("hold_no_valid", {63'd0, ovalid}, 64'd0);
    end
    resp = 4'd3;
    push(5'd7, 64'h77);
    cyc();
    resp = 4'd0; mtag = 4'd3; rdata = 64'h77;
    cyc();
    mtag = 4'd0; rdata = 64'd0;

    // Fill to capacity two per cycle, then drain across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      v1 = 1'b1; st1 = 1'b1; tag1 = 5'(10 + 2*i); addr1 = 64'(64'h8000 + 64'(i*16));
      val1 = 64'(10 + 2*i) * 64'h1111;
      v2 = 1'b1; st2 = 1'b1; tag2 = 5'(11 + 2*i); addr2 = 64'(64'h8008 + 64'(i*16));
      val2 = 64'(11 + 2*i) * 64'h1111;
      push(tag1, 64'd0);
      push(tag2, 64'd0);
      cyc();
      if (i == 2) begin
        chk("fill6_stall1", {63'd0, stall1}, 64'd0);
        chk("fill6_stall2", {63'd0, stall2}, 64'd0);
      end
    end
    chk("full_stall1", {63'd0, stall1}, 64'd1);
    chk("full_stall2", {63'd0, stall2}, 64'd1);
    idle_bus();
    v1 = 1'b1; st1 = 1'b1; tag1 = 5'd31; addr1 = 64'h9000; val1 = 64'hFFFF;
    cyc();
    chk("drop_stall1", {63'd0, stall1}, 64'd1);
    idle_bus();
    resp = 4'd1;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("drain_cmd", {62'd0, cmd}, 64'd2);
      chk("drain_data", mdata, 64'(10 + j) * 64'h1111);
      cyc();
    end
    resp = 4'd0;
    cyc();
    chk("drained_cmd", {62'd0, cmd}, 64'd0);
    chk("drained_stalls", {62'd0, stall1, stall2}, 64'd0);
    chk("sb_empty_2", 64'(sb.size()), 64'd0);

    // Reset while waiting for load data
    v1 = 1'b1; tag1 = 5'd20; addr1 = 64'h5000; st1 = 1'b0;
    cyc();
    idle_bus();
    resp = 4'd5;
    cyc();
    resp = 4'd0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mtag = 4'd5; rdata = 64'h99;
    cyc();
    cyc();
    chk("rst_wait_valid", {63'd0, ovalid}, 64'd0);
    chk("rst_wait_cmd", {62'd0, cmd}, 64'd0);
    chk("rst_wait_stall", {62'd0, stall1, stall2}, 64'd0);
    mtag = 4'd0; rdata = 64'd0;

    // Reset coinciding with the matching data return
    v1 = 1'b1; tag1 = 5'd21; addr1 = 64'h6000; st1 = 1'b0;
    cyc();
    idle_bus();
    resp = 4'd6;
    cyc();
    resp = 4'd0;
    reset = 1'b1; mtag = 4'd6; rdata = 64'hAA;
    cyc();
    chk("rst_ret_valid", {63'd0, ovalid}, 64'd0);
    reset = 1'b0;
    cyc();
    chk("rst_ret_after", {63'd0, ovalid}, 64'd0);
    chk("rst_ret_tag", {59'd0, otag}, 64'd0);
    mtag = 4'd0;
    cyc();
    chk("sb_empty_final", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
